// File: rtl/rgb_hue_sequencer_if.sv
// Control and LED-drive bundle of the RGB hue sequencer: the controller drives mode,
// brightness and pause; the sequencer returns the LED drives, current hue and step strobe.
interface rgb_hue_sequencer_if #(
  parameter int unsigned PWM_BITS = 8
);
  logic [1:0]          mode;
  logic [PWM_BITS-1:0] brightness;
  logic                pause;
  logic                red;
  logic                green;
  logic                blue;
  logic [2:0]          hue_idx;
  logic                step_pulse;

  modport master (
    output mode, brightness, pause,
    input  red, green, blue, hue_idx, step_pulse
  );

  modport slave (
    input  mode, brightness, pause,
    output red, green, blue, hue_idx, step_pulse
  );
endinterface

// File: rtl/rgb_hue_sequencer.sv
// Tri-colour LED sequencer: walks a 6-hue wheel in step/fade/blink/hold modes and drives
// each channel with a brightness-scaled PWM.
module rgb_hue_sequencer #(
  parameter int unsigned STEP_INTERVAL = 2000000,
  parameter int unsigned PWM_BITS      = 8
) (
  input logic               clk,
  input logic               rst_n,
  rgb_hue_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_STEP  = 2'd0,
    MODE_FADE  = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_HOLD  = 2'd3
  } mode_e;

  localparam int unsigned CNT_W = (STEP_INTERVAL > 2) ? $clog2(STEP_INTERVAL) : 1;
  localparam logic [CNT_W-1:0]    TICK_LAST = CNT_W'(STEP_INTERVAL - 1);
  localparam logic [PWM_BITS-1:0] FULL      = {PWM_BITS{1'b1}};

  // Colour mask as {R,G,B}
  function automatic logic [2:0] hue_mask(input logic [2:0] hue);
    logic [2:0] m;
    case (hue)
      3'd0:    m = 3'b100;
      3'd1:    m = 3'b110;
      3'd2:    m = 3'b010;
      3'd3:    m = 3'b011;
      3'd4:    m = 3'b001;
      3'd5:    m = 3'b101;
      default: m = 3'b000;
    endcase
    return m;
  endfunction

  function automatic logic [2:0] hue_next(input logic [2:0] hue);
    return (hue == 3'd5) ? 3'd0 : hue + 3'd1;
  endfunction

  logic [CNT_W-1:0]    tick_cnt_q, tick_cnt_d;
  logic [2:0]          hue_q, hue_d;
  logic [PWM_BITS-1:0] fade_q, fade_d;
  logic                blink_q, blink_d;
  logic                pulse_q, pulse_d;
  mode_e               mode_q;
  logic                mode_vld_q;
  logic [PWM_BITS-1:0] pwm_cnt_q;
  logic [2:0]          rgb_q, rgb_d;

  mode_e               mode_s;
  logic                mode_chg_s;
  logic                tick_last_s;
  logic                tick_s;
  logic [2:0]          cur_mask_s;
  logic [2:0]          nxt_mask_s;
  logic [PWM_BITS-1:0] inten_s [3];
  logic [2*PWM_BITS-1:0] prod_s [3];

  assign mode_s      = mode_e'(bus.mode);
  // The first edge after reset only captures the mode, so entering any mode from reset
  // does not cost an extra cycle of counter clearing.
  assign mode_chg_s  = mode_vld_q && (mode_s != mode_q);
  assign tick_last_s = (tick_cnt_q == TICK_LAST);
  assign tick_s      = tick_last_s && !bus.pause && !mode_chg_s;

  // Next-state for tick counter, hue wheel, fade level, blink phase and step strobe
  always_comb begin
    tick_cnt_d = tick_cnt_q;
    hue_d      = hue_q;
    fade_d     = fade_q;
    blink_d    = blink_q;
    pulse_d    = 1'b0;
    if (mode_chg_s) begin
      tick_cnt_d = {CNT_W{1'b0}};
      fade_d     = {PWM_BITS{1'b0}};
      blink_d    = 1'b1;
    end else if (!bus.pause) begin
      tick_cnt_d = tick_last_s ? {CNT_W{1'b0}} : tick_cnt_q + CNT_W'(1'b1);
      if (tick_s) begin
        case (mode_s)
          MODE_STEP: begin
            hue_d   = hue_next(hue_q);
            pulse_d = 1'b1;
          end
          MODE_FADE: begin
            if (fade_q == FULL) begin
              fade_d  = {PWM_BITS{1'b0}};
              hue_d   = hue_next(hue_q);
              pulse_d = 1'b1;
            end else begin
              fade_d  = fade_q + PWM_BITS'(1'b1);
            end
          end
          MODE_BLINK: blink_d = !blink_q;
          MODE_HOLD:  blink_d = blink_q;
          default:    blink_d = blink_q;
        endcase
      end else begin
        hue_d = hue_q;
      end
    end else begin
      tick_cnt_d = tick_cnt_q;
    end
  end

  // Per-channel intensity, brightness scaling and PWM compare
  always_comb begin
    cur_mask_s = hue_mask(hue_q);
    nxt_mask_s = hue_mask(hue_next(hue_q));
    rgb_d      = 3'b000;
    for (int c = 0; c < 3; c++) begin
      inten_s[c] = {PWM_BITS{1'b0}};
      case (mode_s)
        MODE_STEP, MODE_HOLD: inten_s[c] = cur_mask_s[c] ? FULL : {PWM_BITS{1'b0}};
        MODE_FADE: begin
          case ({cur_mask_s[c], nxt_mask_s[c]})
            2'b11:   inten_s[c] = FULL;
            2'b10:   inten_s[c] = FULL - fade_q;
            2'b01:   inten_s[c] = fade_q;
            default: inten_s[c] = {PWM_BITS{1'b0}};
          endcase
        end
        MODE_BLINK: inten_s[c] = (cur_mask_s[c] && blink_q) ? FULL : {PWM_BITS{1'b0}};
        default:    inten_s[c] = {PWM_BITS{1'b0}};
      endcase
      prod_s[c] = {{PWM_BITS{1'b0}}, inten_s[c]} * {{PWM_BITS{1'b0}}, bus.brightness};
      rgb_d[c]  = (prod_s[c][2*PWM_BITS-1:PWM_BITS] > pwm_cnt_q);
    end
  end

  // Sequencer state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q <= {CNT_W{1'b0}};
      hue_q      <= 3'd0;
      fade_q     <= {PWM_BITS{1'b0}};
      blink_q    <= 1'b1;
      pulse_q    <= 1'b0;
      mode_q     <= MODE_STEP;
      mode_vld_q <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      hue_q      <= hue_d;
      fade_q     <= fade_d;
      blink_q    <= blink_d;
      pulse_q    <= pulse_d;
      mode_q     <= mode_s;
      mode_vld_q <= 1'b1;
    end
  end

  // Free-running PWM counter and registered LED drives
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_q <= {PWM_BITS{1'b0}};
      rgb_q     <= 3'b000;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1'b1);
      rgb_q     <= rgb_d;
    end
  end

  assign bus.red        = rgb_q[2];
  assign bus.green      = rgb_q[1];
  assign bus.blue       = rgb_q[0];
  assign bus.hue_idx    = hue_q;
  assign bus.step_pulse = pulse_q;

endmodule

// File: tb/tb_rgb_hue_sequencer.sv
// Directed bench for rgb_hue_sequencer with STEP_INTERVAL=4, PWM_BITS=4; expected values
// are hand-derived from the tick timing and duty = (intensity*brightness)>>4.
module tb_rgb_hue_sequencer;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  int   r_cnt, g_cnt, b_cnt, s_cnt, s_tot;

  rgb_hue_sequencer_if #(.PWM_BITS(4)) bus_if ();

  rgb_hue_sequencer #(
    .STEP_INTERVAL(4),
    .PWM_BITS     (4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic count_n(input int n, output int r, output int g, output int b, output int s);
    r = 0; g = 0; b = 0; s = 0;
    repeat (n) begin
      @(negedge clk);
      r += int'(bus_if.red);
      g += int'(bus_if.green);
      b += int'(bus_if.blue);
      s += int'(bus_if.step_pulse);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    s_tot = 0;
    rst_n = 1'b0;
    bus_if.mode       = 2'd0;
    bus_if.brightness = 4'd15;
    bus_if.pause      = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_hue", 32'(bus_if.hue_idx), 32'd0);
    check("rst_rgb", 32'({bus_if.red, bus_if.green, bus_if.blue}), 32'd0);
    check("rst_step", 32'(bus_if.step_pulse), 32'd0);

    // STEP: hue advances every 4 cycles, strobe on each change
    rst_n = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      check($sformatf("step_hue%0d", i), 32'(bus_if.hue_idx), 32'((i / 4) % 6));
      check($sformatf("step_pls%0d", i), 32'(bus_if.step_pulse), 32'((i % 4) == 0));
    end

    // Pause two cycles into RED: colour keeps PWMing, hue frozen
    repeat (2) @(negedge clk);
    check("pre_pause_hue", 32'(bus_if.hue_idx), 32'd0);
    bus_if.pause = 1'b1;
    @(negedge clk);
    count_n(16, r_cnt, g_cnt, b_cnt, s_cnt);
    check("pause_red14", 32'(r_cnt), 32'd14);
    check("pause_gb0", 32'(g_cnt + b_cnt), 32'd0);
    s_tot = s_cnt;
    count_n(3, r_cnt, g_cnt, b_cnt, s_cnt);
    check("pause_no_step", 32'(s_tot + s_cnt), 32'd0);
    check("pause_hue", 32'(bus_if.hue_idx), 32'd0);
    bus_if.pause = 1'b0;
    @(negedge clk);
    check("resume_hue_hold", 32'(bus_if.hue_idx), 32'd0);
    @(negedge clk);
    check("resume_hue_adv", 32'(bus_if.hue_idx), 32'd1);
    check("resume_pulse", 32'(bus_if.step_pulse), 32'd1);

    // Brightness 8 in YELLOW, then brightness 0
    bus_if.pause      = 1'b1;
    bus_if.brightness = 4'd8;
    @(negedge clk);
    count_n(16, r_cnt, g_cnt, b_cnt, s_cnt);
    check("br8_red7", 32'(r_cnt), 32'd7);
    check("br8_green7", 32'(g_cnt), 32'd7);
    check("br8_blue0", 32'(b_cnt), 32'd0);
    bus_if.brightness = 4'd0;
    @(negedge clk);
    count_n(16, r_cnt, g_cnt, b_cnt, s_cnt);
    check("br0_all0", 32'(r_cnt + g_cnt + b_cnt), 32'd0);

    // FADE from RED
    rst_n = 1'b0;
    bus_if.mode       = 2'd1;
    bus_if.brightness = 4'd15;
    bus_if.pause      = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("fade10_hue", 32'(bus_if.hue_idx), 32'd0);
    bus_if.pause = 1'b1;
    @(negedge clk);
    count_n(16, r_cnt, g_cnt, b_cnt, s_cnt);
    check("fade10_red14", 32'(r_cnt), 32'd14);
    check("fade10_green9", 32'(g_cnt), 32'd9);
    check("fade10_blue0", 32'(b_cnt), 32'd0);
    bus_if.pause = 1'b0;
    repeat (20) @(negedge clk);
    check("fade15_hue", 32'(bus_if.hue_idx), 32'd0);
    bus_if.pause = 1'b1;
    @(negedge clk);
    count_n(16, r_cnt, g_cnt, b_cnt, s_cnt);
    check("fade15_red14", 32'(r_cnt), 32'd14);
    check("fade15_green14", 32'(g_cnt), 32'd14);
    bus_if.pause = 1'b0;
    repeat (3) @(negedge clk);
    check("fade_wrap_pre", 32'(bus_if.hue_idx), 32'd0);
    @(negedge clk);
    check("fade_wrap_hue", 32'(bus_if.hue_idx), 32'd1);
    check("fade_wrap_pulse", 32'(bus_if.step_pulse), 32'd1);

    // STEP up to CYAN; the mode change restarts the tick counter
    bus_if.mode = 2'd0;
    repeat (5) @(negedge clk);
    check("to_green", 32'(bus_if.hue_idx), 32'd2);
    check("to_green_pulse", 32'(bus_if.step_pulse), 32'd1);
    repeat (4) @(negedge clk);
    check("to_cyan", 32'(bus_if.hue_idx), 32'd3);

    // BLINK at CYAN: 4 cycles on, 4 off, 4 on
    bus_if.mode = 2'd2;
    @(negedge clk);
    count_n(4, r_cnt, g_cnt, b_cnt, s_cnt);
    s_tot = s_cnt;
    check("blink_on1_g", 32'(g_cnt >= 2), 32'd1);
    check("blink_on1_b", 32'(b_cnt >= 2), 32'd1);
    check("blink_on1_r", 32'(r_cnt), 32'd0);
    count_n(4, r_cnt, g_cnt, b_cnt, s_cnt);
    s_tot += s_cnt;
    check("blink_off", 32'(r_cnt + g_cnt + b_cnt), 32'd0);
    count_n(4, r_cnt, g_cnt, b_cnt, s_cnt);
    s_tot += s_cnt;
    check("blink_on2_g", 32'(g_cnt >= 2), 32'd1);
    check("blink_hue", 32'(bus_if.hue_idx), 32'd3);
    check("blink_no_step", 32'(s_tot), 32'd0);

    // FADE to level 9, then asynchronous reset
    bus_if.mode = 2'd1;
    @(negedge clk);
    repeat (36) @(negedge clk);
    check("fade9_hue", 32'(bus_if.hue_idx), 32'd3);
    for (int k = 0; k < 4 && bus_if.blue !== 1'b1; k++) @(negedge clk);
    check("fade9_blue_on", 32'(bus_if.blue), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_rgb", 32'({bus_if.red, bus_if.green, bus_if.blue}), 32'd0);
    check("async_rst_hue", 32'(bus_if.hue_idx), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 64; i++) begin
      @(negedge clk);
      check($sformatf("rst_fade_hue%0d", i), 32'(bus_if.hue_idx), 32'(i == 64));
      check($sformatf("rst_fade_pls%0d", i), 32'(bus_if.step_pulse), 32'(i == 64));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
